// File: rtl/mul_booth_seq.sv
// mul_booth_seq: iterative radix-4 Booth multiplier that adds one partial product per clock.
// It supports signed/unsigned operand modes and uses valid/ready handshakes on both sides.
module mul_booth_seq #(
    parameter int WIDTH     = 64,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_signed,
    input  logic             b_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);
    localparam int N  = WIDTH / 2 + 1;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    acc, mcand, pp, a_ext;
    logic [WIDTH+2:0] mplr;
    logic [2:0]       w;
    logic             pos1, pos2, neg1, neg2;

    // The accumulator keeps only the product bits; the extra Booth headroom bits would be truncated anyway.
    assign a_ext = {{WIDTH{a_signed & a[WIDTH-1]}}, a};
    assign w     = mplr[2:0];

    always_comb begin
        pos1 = (w == 3'b001) || (w == 3'b010);
        pos2 = (w == 3'b011);
        neg1 = (w == 3'b101) || (w == 3'b110);
        neg2 = (w == 3'b100);
        pp   = pos1 ? mcand :
               pos2 ? {mcand[PW-2:0], 1'b0} :
               neg1 ? -mcand :
               neg2 ? -{mcand[PW-2:0], 1'b0} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mcand <= a_ext;
                    mplr  <= {{2{b_signed & b[WIDTH-1]}}, b, 1'b0};
                    acc   <= '0;
                    cnt   <= '0;
                    state <= (FAST_ZERO && (a == '0 || b == '0)) ? DONE : CALC;
                end
                CALC: begin
                    acc   <= acc + pp;
                    mcand <= {mcand[PW-3:0], 2'b00};
                    mplr  <= {2'b00, mplr[WIDTH+2:2]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result_hi = acc[PW-1:WIDTH];
    assign result_lo = acc[WIDTH-1:0];
endmodule
